// File: rtl/sram_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sram_arbiter_if
// Description : Fetch-port and load/store-port handshake bundle between the
//               pipeline (master side) and the SRAM arbiter (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;
    // Fetch port (IF stage)
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    // Load/store port (MEM stage)
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack
    );

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output if_rdata, if_ack, mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one single-port SRAM between the fetch port and the
//               load/store port. Each access holds the SRAM for WAIT_CYCLES
//               clocks, then returns data and a one-cycle ack to its owner.
//               Under contention the grant alternates between the ports.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,            // asynchronous, active low
    sram_arbiter_if.slave    bus,
    output logic             sram_ce_o,
    output logic             sram_we_o,
    output logic [3:0]       sram_sel_o,
    output logic [31:0]      sram_addr_o,
    output logic [31:0]      sram_wdata_o,
    input  wire logic [31:0] sram_rdata_i,
    output logic             stallreq_if_o,
    output logic             stallreq_mem_o,
    output logic [1:0]       grant_o
);

    // Counter value on the edge that completes an access
    localparam logic [3:0] C_LAST_CNT   = 4'(WAIT_CYCLES - 1);
    localparam logic [1:0] C_GRANT_NONE = 2'b00;
    localparam logic [1:0] C_GRANT_IF   = 2'b01;
    localparam logic [1:0] C_GRANT_MEM  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_ACC  = 2'd1,
        S_MEM_ACC = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_last_mem;
    logic        r_if_ack;
    logic        r_mem_ack;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        r_ce;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_grant;

    logic        w_req_if;
    logic        w_req_mem;
    logic        w_grant_if;
    logic        w_grant_mem;
    logic        w_done;

    // A requester acked this cycle is still holding req high; mask it so it
    // is not granted a second time.
    assign w_req_if  = bus.if_req  & ~r_if_ack;
    assign w_req_mem = bus.mem_req & ~r_mem_ack;
    assign w_done    = (r_cnt == C_LAST_CNT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and next-state: MEM has priority unless it won last time
    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_mem = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_mem && (!w_req_if || !r_last_mem)) begin
                    w_state_nxt = S_MEM_ACC;
                    w_grant_mem = 1'b1;
                end else if (w_req_if) begin
                    w_state_nxt = S_IF_ACC;
                    w_grant_if  = 1'b1;
                end
            end
            S_IF_ACC, S_MEM_ACC: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Access datapath: latch request on grant, count wait cycles, complete
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_last_mem  <= 1'b0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_mem_rdata <= 32'd0;
            r_ce        <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_grant     <= C_GRANT_NONE;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            if (w_grant_mem) begin
                r_addr     <= bus.mem_addr;
                r_we       <= bus.mem_we;
                r_sel      <= bus.mem_sel;
                r_wdata    <= bus.mem_wdata;
                r_ce       <= 1'b1;
                r_grant    <= C_GRANT_MEM;
                r_cnt      <= 4'd0;
                r_last_mem <= 1'b1;
            end else if (w_grant_if) begin
                // Fetches are always full-word reads
                r_addr     <= bus.if_addr;
                r_we       <= 1'b0;
                r_sel      <= 4'b1111;
                r_ce       <= 1'b1;
                r_grant    <= C_GRANT_IF;
                r_cnt      <= 4'd0;
                r_last_mem <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_done) begin
                    r_ce    <= 1'b0;
                    r_we    <= 1'b0;
                    r_grant <= C_GRANT_NONE;
                    if (r_state == S_IF_ACC) begin
                        r_if_rdata <= sram_rdata_i;
                        r_if_ack   <= 1'b1;
                    end else begin
                        // A store leaves the last load result in place
                        if (!r_we) begin
                            r_mem_rdata <= sram_rdata_i;
                        end
                        r_mem_ack <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.if_rdata   = r_if_rdata;
    assign bus.if_ack     = r_if_ack;
    assign bus.mem_rdata  = r_mem_rdata;
    assign bus.mem_ack    = r_mem_ack;
    assign sram_ce_o      = r_ce;
    assign sram_we_o      = r_we;
    assign sram_sel_o     = r_sel;
    assign sram_addr_o    = r_addr;
    assign sram_wdata_o   = r_wdata;
    assign grant_o        = r_grant;
    assign stallreq_if_o  = bus.if_req  & ~r_if_ack;
    assign stallreq_mem_o = bus.mem_req & ~r_mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter. Three instances with
//               WAIT_CYCLES = 1, 3 and 15 each get their own SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int N = 3;

    function automatic int wait_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 15;
        endcase
    endfunction

    // Power-on SRAM contents; word 4 holds a known instruction
    function automatic logic [31:0] hash(input int g, input int w);
        if (w == 4) return 32'h3401_1100;
        return (32'(w) * 32'h9E37_79B1) ^ (32'(g) << 24) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        if_req    [N];
    logic [31:0] if_addr   [N];
    logic [31:0] if_rdata  [N];
    logic        if_ack    [N];
    logic        mem_req   [N];
    logic        mem_we    [N];
    logic [3:0]  mem_sel   [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        mem_ack   [N];
    logic        stall_if  [N];
    logic        stall_mem [N];
    logic        ce        [N];
    logic        we        [N];
    logic [3:0]  sel       [N];
    logic [31:0] saddr     [N];
    logic [31:0] swdata    [N];
    logic [31:0] srdata    [N];
    logic [1:0]  grant     [N];

    logic [31:0] ref_mem [N][64];
    int n_pass  = 0;
    int n_total = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [31:0] mem_q [64];
        logic [63:0] wr_q = '0;
        logic [5:0]  widx;
        sram_arbiter_if bus ();

        assign widx          = saddr[g][7:2];
        assign bus.if_req    = if_req[g];
        assign bus.if_addr   = if_addr[g];
        assign bus.mem_req   = mem_req[g];
        assign bus.mem_we    = mem_we[g];
        assign bus.mem_sel   = mem_sel[g];
        assign bus.mem_addr  = mem_addr[g];
        assign bus.mem_wdata = mem_wdata[g];
        assign if_rdata[g]   = bus.if_rdata;
        assign if_ack[g]     = bus.if_ack;
        assign mem_rdata[g]  = bus.mem_rdata;
        assign mem_ack[g]    = bus.mem_ack;
        assign srdata[g]     = wr_q[widx] ? mem_q[widx] : hash(g, int'(widx));

        always @(posedge clk) begin
            if (ce[g] && we[g]) begin
                mem_q[widx] <= merge(wr_q[widx] ? mem_q[widx] : hash(g, int'(widx)), swdata[g], sel[g]);
                wr_q[widx]  <= 1'b1;
            end
        end

        sram_arbiter #(.WAIT_CYCLES(wait_of(g))) u_dut (
            .clk            (clk),
            .rst            (rst),
            .bus            (bus),
            .sram_ce_o      (ce[g]),
            .sram_we_o      (we[g]),
            .sram_sel_o     (sel[g]),
            .sram_addr_o    (saddr[g]),
            .sram_wdata_o   (swdata[g]),
            .sram_rdata_i   (srdata[g]),
            .stallreq_if_o  (stall_if[g]),
            .stallreq_mem_o (stall_mem[g]),
            .grant_o        (grant[g])
        );
    end

    // Idle all requesters, pulse reset; returns 1ns after a rising edge
    task automatic do_reset();
        for (int d = 0; d < N; d++) begin
            if_req[d] = 1'b0;  if_addr[d] = '0;  mem_req[d] = 1'b0; mem_we[d] = 1'b0;
            mem_sel[d] = '0;   mem_addr[d] = '0; mem_wdata[d] = '0;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            n_total++;
            if ({grant[d], if_ack[d], mem_ack[d], ce[d], we[d], sel[d], saddr[d], swdata[d],
                 if_rdata[d], mem_rdata[d]} !== '0)
                $display("FAIL reset_outputs[%0d]: got grant=%b ce=%b addr=%h rdata=%h/%h, want all zero",
                         d, grant[d], ce[d], saddr[d], if_rdata[d], mem_rdata[d]);
            else n_pass++;
        end
        do_reset();
    endtask

    // WAIT_CYCLES=1 fetch of a known instruction word
    task automatic test_single_fetch();
        do_reset();
        if_addr[0] = 32'h10; if_req[0] = 1'b1;
        @(negedge clk);
        n_total++; if ({stall_if[0], if_ack[0], grant[0]} !== 4'b1000) $display("FAIL fetch_req_cycle: got stall=%b ack=%b grant=%b, want 1 0 00", stall_if[0], if_ack[0], grant[0]); else n_pass++;
        @(negedge clk);
        n_total++; if ({grant[0], ce[0], we[0], sel[0], saddr[0]} !== {2'b01, 1'b1, 1'b0, 4'hF, 32'h10}) $display("FAIL fetch_busy: got grant=%b ce=%b we=%b sel=%h addr=%h", grant[0], ce[0], we[0], sel[0], saddr[0]); else n_pass++;
        n_total++; if (stall_if[0] !== 1'b1) $display("FAIL fetch_stall_busy: got %b want 1", stall_if[0]); else n_pass++;
        @(negedge clk);
        n_total++; if ({if_ack[0], stall_if[0], ce[0], grant[0]} !== 5'b10000) $display("FAIL fetch_ack_cycle: got ack=%b stall=%b ce=%b grant=%b, want 1 0 0 00", if_ack[0], stall_if[0], ce[0], grant[0]); else n_pass++;
        n_total++; if (if_rdata[0] !== 32'h3401_1100) $display("FAIL fetch_rdata: got %h want 34011100", if_rdata[0]); else n_pass++;
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        @(negedge clk);
        n_total++; if ({if_ack[0], if_rdata[0]} !== {1'b0, 32'h3401_1100}) $display("FAIL fetch_after: got ack=%b rdata=%h, want 0 34011100", if_ack[0], if_rdata[0]); else n_pass++;
    endtask

    // WAIT_CYCLES=3 partial store followed by a load of the same word
    task automatic test_store_load();
        logic [31:0] exp;
        do_reset();
        exp = merge(ref_mem[1][0], 32'hDEAD_BEEF, 4'b0011);
        ref_mem[1][0] = exp;
        mem_req[1] = 1'b1; mem_we[1] = 1'b1; mem_sel[1] = 4'b0011;
        mem_addr[1] = 32'h100; mem_wdata[1] = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k <= 3) begin
                n_total++; if ({ce[1], we[1], sel[1], saddr[1], swdata[1], mem_ack[1]} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1'b0}) $display("FAIL store_busy[%0d]: got ce=%b we=%b sel=%b addr=%h wdata=%h ack=%b", k, ce[1], we[1], sel[1], saddr[1], swdata[1], mem_ack[1]); else n_pass++;
            end else begin
                n_total++; if ({mem_ack[1], we[1], ce[1], mem_rdata[1]} !== {3'b100, 32'h0}) $display("FAIL store_ack: got ack=%b we=%b ce=%b rdata=%h, want 1 0 0 00000000", mem_ack[1], we[1], ce[1], mem_rdata[1]); else n_pass++;
            end
        end
        mem_we[1] = 1'b0; mem_sel[1] = 4'hF;
        @(posedge clk); #1;
        n_total++; if (grant[1] !== 2'b00) $display("FAIL idle_gap: got grant=%b want 00", grant[1]); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k <= 3) begin
                n_total++; if ({grant[1], we[1], mem_ack[1]} !== 4'b1000) $display("FAIL load_busy[%0d]: got grant=%b we=%b ack=%b", k, grant[1], we[1], mem_ack[1]); else n_pass++;
            end else begin
                n_total++; if ({mem_ack[1], mem_rdata[1]} !== {1'b1, exp}) $display("FAIL load_data: got ack=%b rdata=%h, want 1 %h", mem_ack[1], mem_rdata[1], exp); else n_pass++;
            end
        end
        mem_req[1] = 1'b0;
    endtask

    // Requester changes its address after the grant edge
    task automatic test_addr_change();
        do_reset();
        if_addr[1] = 32'h10; if_req[1] = 1'b1;
        @(posedge clk); #1;
        if_addr[1] = 32'h20;
        for (int k = 1; k <= 3; k++) begin
            n_total++; if ({ce[1], saddr[1]} !== {1'b1, 32'h10}) $display("FAIL addr_hold[%0d]: got ce=%b addr=%h want 1 00000010", k, ce[1], saddr[1]); else n_pass++;
            @(posedge clk); #1;
        end
        n_total++; if ({if_ack[1], if_rdata[1]} !== {1'b1, ref_mem[1][4]}) $display("FAIL addr_hold_data: got ack=%b rdata=%h want 1 %h", if_ack[1], if_rdata[1], ref_mem[1][4]); else n_pass++;
        if_req[1] = 1'b0;
    endtask

    // Asynchronous reset while a load is two cycles into its access
    task automatic test_async_reset();
        do_reset();
        mem_req[1] = 1'b1; mem_we[1] = 1'b0; mem_sel[1] = 4'hF; mem_addr[1] = 32'h40;
        repeat (wait_of(1) + 1) @(posedge clk);
        #1;
        n_total++; if ({mem_ack[1], mem_rdata[1]} !== {1'b1, ref_mem[1][16]}) $display("FAIL arst_first_load: got ack=%b rdata=%h want 1 %h", mem_ack[1], mem_rdata[1], ref_mem[1][16]); else n_pass++;
        mem_addr[1] = 32'h44;
        repeat (3) @(posedge clk);
        #2;
        n_total++; if ({grant[1], ce[1]} !== 3'b101) $display("FAIL arst_pre: got grant=%b ce=%b want 10 1", grant[1], ce[1]); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if ({grant[1], ce[1], we[1], sel[1], saddr[1], swdata[1], mem_ack[1], mem_rdata[1], if_rdata[1]} !== '0) $display("FAIL arst_clear: got grant=%b ce=%b addr=%h ack=%b rdata=%h", grant[1], ce[1], saddr[1], mem_ack[1], mem_rdata[1]); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({mem_ack[1], ce[1], grant[1]} !== 4'b0000) $display("FAIL arst_held: got ack=%b ce=%b grant=%b want 0 0 00", mem_ack[1], ce[1], grant[1]); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if ({grant[1], saddr[1]} !== {2'b10, 32'h44}) $display("FAIL arst_regrant: got grant=%b addr=%h want 10 00000044", grant[1], saddr[1]); else n_pass++;
        repeat (wait_of(1)) @(posedge clk);
        #1;
        n_total++; if ({mem_ack[1], mem_rdata[1]} !== {1'b1, ref_mem[1][17]}) $display("FAIL arst_reload: got ack=%b rdata=%h want 1 %h", mem_ack[1], mem_rdata[1], ref_mem[1][17]); else n_pass++;
        mem_req[1] = 1'b0;
    endtask

    // Longest legal wait: ack in the 16th cycle after the grant edge
    task automatic test_long_wait();
        do_reset();
        mem_req[2] = 1'b1; mem_we[2] = 1'b0; mem_sel[2] = 4'hF; mem_addr[2] = 32'h2C;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k <= 15) begin
                n_total++; if ({grant[2], mem_ack[2]} !== 3'b100) $display("FAIL w15_busy[%0d]: got grant=%b ack=%b want 10 0", k, grant[2], mem_ack[2]); else n_pass++;
            end else if (k == 16) begin
                n_total++; if ({mem_ack[2], grant[2], mem_rdata[2]} !== {3'b100, ref_mem[2][11]}) $display("FAIL w15_ack: got ack=%b grant=%b rdata=%h want 1 00 %h", mem_ack[2], grant[2], mem_rdata[2], ref_mem[2][11]); else n_pass++;
                mem_req[2] = 1'b0;
            end else begin
                n_total++; if (mem_ack[2] !== 1'b0) $display("FAIL w15_pulse: got ack=%b want 0", mem_ack[2]); else n_pass++;
            end
        end
    endtask

    // Random traffic on instance d, checked cycle by cycle against a
    // transaction-timing model: a grant decided in cycle c owns the SRAM in
    // cycles c+1..c+W and is acked in cycle c+W+1, when the next decision
    // may be taken. contend=1 keeps both requests permanently raised.
    task automatic test_traffic(input int d, input int ncyc, input bit contend);
        int w, next_free, g_at, own, ack_if_at, ack_mem_at, nobs;
        bit last_mem, eff_if, eff_mem, exp_ifack, exp_memack, prev_busy, l_memload;
        logic [1:0]  exp_grant;
        logic [31:0] l_addr, l_wdata, exp_ifr, exp_memr, pend_if, pend_mem;
        logic        l_we;
        logic [3:0]  l_sel;
        w = wait_of(d); next_free = 0; g_at = -100; own = 0; ack_if_at = -100; ack_mem_at = -100;
        nobs = 0; last_mem = 1'b0; prev_busy = 1'b0; l_memload = 1'b0;
        l_addr = '0; l_wdata = '0; l_we = 1'b0; l_sel = '0;
        exp_ifr = '0; exp_memr = '0; pend_if = '0; pend_mem = '0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (!if_req[d] || ack_if_at == c - 1) begin
                if_req[d]  = contend || ($urandom_range(0, 2) == 0);
                if_addr[d] = $urandom & 32'hFF;
            end else if ($urandom_range(0, 3) == 0) begin
                if_addr[d] = $urandom & 32'hFF;
            end
            if (!mem_req[d] || ack_mem_at == c - 1) begin
                mem_req[d]   = contend || ($urandom_range(0, 2) == 0);
                mem_we[d]    = 1'($urandom_range(0, 1));
                mem_sel[d]   = 4'($urandom_range(1, 15));
                mem_addr[d]  = $urandom & 32'hFF;
                mem_wdata[d] = $urandom;
            end else if ($urandom_range(0, 3) == 0) begin
                mem_addr[d]  = $urandom & 32'hFF;
                mem_wdata[d] = $urandom;
            end
            @(negedge clk);
            exp_grant  = (c > g_at && c <= g_at + w) ? 2'(own) : 2'b00;
            exp_ifack  = (c == ack_if_at);
            exp_memack = (c == ack_mem_at);
            if (exp_ifack) exp_ifr = pend_if;
            if (exp_memack && l_memload) exp_memr = pend_mem;
            n_total++; if ({grant[d], if_ack[d], mem_ack[d]} !== {exp_grant, exp_ifack, exp_memack}) $display("FAIL traffic%0d_ctl c=%0d: got grant=%b ack=%b%b want %b %b%b", d, c, grant[d], if_ack[d], mem_ack[d], exp_grant, exp_ifack, exp_memack); else n_pass++;
            n_total++; if ({ce[d], we[d]} !== {exp_grant != 2'b00, exp_grant != 2'b00 && l_we}) $display("FAIL traffic%0d_cewe c=%0d: got ce=%b we=%b", d, c, ce[d], we[d]); else n_pass++;
            if (exp_grant != 2'b00) begin
                n_total++; if ({saddr[d], sel[d]} !== {l_addr, l_sel}) $display("FAIL traffic%0d_bus c=%0d: got addr=%h sel=%h want %h %h", d, c, saddr[d], sel[d], l_addr, l_sel); else n_pass++;
                if (l_we) begin
                    n_total++; if (swdata[d] !== l_wdata) $display("FAIL traffic%0d_wdata c=%0d: got %h want %h", d, c, swdata[d], l_wdata); else n_pass++;
                end
            end
            n_total++; if ({if_rdata[d], mem_rdata[d]} !== {exp_ifr, exp_memr}) $display("FAIL traffic%0d_rdata c=%0d: got %h/%h want %h/%h", d, c, if_rdata[d], mem_rdata[d], exp_ifr, exp_memr); else n_pass++;
            n_total++; if ({stall_if[d], stall_mem[d]} !== {if_req[d] && !exp_ifack, mem_req[d] && !exp_memack}) $display("FAIL traffic%0d_stall c=%0d: got %b%b", d, c, stall_if[d], stall_mem[d]); else n_pass++;
            if (contend && grant[d] != 2'b00 && !prev_busy) begin
                n_total++; if (grant[d] !== ((nobs % 2 == 0) ? 2'b10 : 2'b01)) $display("FAIL contention_order[%0d]: got %b want %b", nobs, grant[d], (nobs % 2 == 0) ? 2'b10 : 2'b01); else n_pass++;
                nobs++;
            end
            prev_busy = (grant[d] != 2'b00);
            if (c >= next_free) begin
                eff_if  = if_req[d]  && !exp_ifack;
                eff_mem = mem_req[d] && !exp_memack;
                if (eff_mem && (!eff_if || !last_mem)) begin
                    own = 2; l_addr = mem_addr[d]; l_we = mem_we[d]; l_sel = mem_sel[d];
                    l_wdata = mem_wdata[d]; l_memload = !mem_we[d];
                    if (l_we) ref_mem[d][l_addr[7:2]] = merge(ref_mem[d][l_addr[7:2]], l_wdata, l_sel);
                    else pend_mem = ref_mem[d][l_addr[7:2]];
                    last_mem = 1'b1; g_at = c; next_free = c + w + 1; ack_mem_at = c + w + 1;
                end else if (eff_if) begin
                    own = 1; l_addr = if_addr[d]; l_we = 1'b0; l_sel = 4'hF;
                    pend_if = ref_mem[d][l_addr[7:2]];
                    last_mem = 1'b0; g_at = c; next_free = c + w + 1; ack_if_at = c + w + 1;
                end
            end
            @(posedge clk); #1;
        end
        if (contend) begin
            n_total++; if (nobs < 4) $display("FAIL contention_count: got %0d grants want >= 4", nobs); else n_pass++;
        end
        do_reset();
    endtask

    initial begin
        for (int d = 0; d < N; d++)
            for (int i = 0; i < 64; i++) ref_mem[d][i] = hash(d, i);
        do_reset();
        test_reset();
        test_single_fetch();
        test_store_load();
        test_addr_change();
        test_async_reset();
        test_long_wait();
        test_traffic(1, 80, 1'b1);
        test_traffic(0, 40, 1'b1);
        test_traffic(0, 300, 1'b0);
        test_traffic(1, 300, 1'b0);
        test_traffic(2, 400, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port instruction/data SRAM between the IF stage (fetch port) and the MEM stage (load/store port) of the 5-stage pipeline.
- Each access runs for a fixed number of wait cycles set by a parameter.
- Returns read data and a one-cycle ack to the requester that was granted.
- Drives per-port stall requests, which feed the pipeline stall controller so the pipeline freezes while an access is outstanding.

Parameters:
- WAIT_CYCLES, 1, SRAM read latency in clocks from address presented to sram_rdata_i valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched instruction (registered).
- if_ack  out  1  one-cycle fetch completion pulse.
- mem_req  in  1  load/store request; held high until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_sel  in  4  byte enables.
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data (registered).
- mem_ack  out  1  one-cycle load/store completion pulse.
- sram_ce_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_sel_o  out  4  SRAM byte enables.
- sram_addr_o  out  32  SRAM address.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data.
- stallreq_if_o  out  1  fetch stall request = if_req & ~if_ack (combinational).
- stallreq_mem_o  out  1  MEM stall request = mem_req & ~mem_ack (combinational).
- grant_o  out  2  current owner: 00 none, 01 IF, 10 MEM.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0, last_mem=0.
  - All registered outputs 0: rdata regs, acks, sram_* outputs, grant_o.
- States: IDLE, IF_ACC, MEM_ACC.
- IDLE arbitration:
  - Effective requests are req_if = if_req & ~if_ack and req_mem = mem_req & ~mem_ack. A requester acked in the current cycle is masked.
  - Only req_mem: go to MEM_ACC.
  - Only req_if: go to IF_ACC.
  - Both pending: MEM wins unless last_mem=1, in which case IF wins. Under sustained contention grants therefore alternate.
  - last_mem is set to 1 on a MEM grant and cleared on an IF grant.
- On the grant edge, latch the granted port's address (plus we/sel/wdata for MEM) into the sram_* output registers, set sram_ce_o=1, set grant_o, and set cnt=0.
- IF access drives sram_we_o=0 and sram_sel_o=4'b1111.
- Requester inputs changing after the grant are ignored for that access.
- In an ACC state, every edge increments cnt. On the edge where cnt==WAIT_CYCLES-1:
  - A read captures sram_rdata_i into the owner's rdata register. A store leaves mem_rdata unchanged.
  - The owner's ack goes high for exactly one cycle.
  - sram_ce_o, sram_we_o and grant_o return to 0, and state goes to IDLE.
- Latency: request high before edge E0 (grant) gives ack high in the cycle after edge E0+WAIT_CYCLES. The SRAM is busy for WAIT_CYCLES cycles; there is one IDLE cycle between back-to-back accesses.
- if_rdata and mem_rdata hold their value until the next read completes on the same port.
- Never both acks high in the same cycle, and never both grant_o bits set.
- Reset mid-access aborts immediately: no ack, SRAM deselected, rdata regs cleared.
- Write enable to the SRAM is only asserted while ce=1.

Test Plan:
- Single fetch, WAIT_CYCLES=1, if_addr=0x0000_0010, SRAM returns 0x3401_1100:
  - if_ack pulses exactly 2 cycles after req seen.
  - if_rdata=0x3401_1100.
  - stallreq_if_o high until the ack cycle.
- Store then load, WAIT_CYCLES=3:
  - Store: mem_we=1, sel=4'b0011, addr=0x100, wdata=0xDEAD_BEEF. SRAM sees we=1, sel=0011 for 3 cycles; mem_rdata unchanged.
  - Load from 0x100 returns the model value; mem_ack arrives 4 cycles after grant.
- Contention, both requests continuously high:
  - Grant order is MEM, IF, MEM, IF.
  - Acks never coincide; grant_o never equals 11.
- Address change mid-access:
  - if_addr switches 0x10 to 0x20 one cycle after grant.
  - sram_addr_o stays 0x10 until the access ends.
- Async reset asserted while in MEM_ACC with cnt=1:
  - All outputs 0 without waiting for a clock edge; no mem_ack.
  - After release, a pending mem_req is re-granted from IDLE.
- WAIT_CYCLES=15 single load:
  - cnt does not overflow.
  - Ack arrives 16 cycles after the grant edge.
